// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and IOBUS constants for the UART receiver
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam logic [31:0] UART_RX_DATA_AD = 32'h1124_0000;
  localparam logic [31:0] UART_RX_STAT_AD = 32'h1128_0000;

  localparam int STAT_VALID_BIT     = 0;
  localparam int STAT_FULL_BIT      = 1;
  localparam int STAT_FRAME_ERR_BIT = 2;
  localparam int STAT_OVERRUN_BIT   = 3;
  localparam int STAT_PAR_ERR_BIT   = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead synchronous FIFO; head is 0 when empty
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             not_empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign not_empty = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop && not_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign do_push   = push && (!full || do_pop);
  assign head      = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver into a show-ahead FIFO with sticky error flags.
// Define UART_RX_PARITY_EN to expect an even-parity bit and expose PAR_ERR.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  input  logic       RD_EN,
  input  logic       CLR_ERR,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FULL,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       INTRPT
`ifdef UART_RX_PARITY_EN
  ,
  output logic       PAR_ERR
`endif
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT) + 1;
  localparam int AW           = $clog2(FIFO_DEPTH);

  logic              rx_m, rx_s, rx_d;
  rx_state_t         state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [7:0]        shreg, shreg_nxt;
  logic              expired;
  logic              push_req;
  logic              frame_set;
  logic              pop_ok;
  logic              overrun_set;
  logic [AW:0]       count;
`ifdef UART_RX_PARITY_EN
  logic              par_set;
`endif

  // Reset to the idle level so the edge detector never sees a false start out of reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign expired = (cnt == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  // Reloads use CLKS_PER_BIT-1 because the expiry cycle itself counts as one bit clock.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    push_req    = 1'b0;
    frame_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_set     = 1'b0;
`endif
    case (state)
      IDLE: begin
        // Falling edge only: a line held low after a break cannot restart a frame.
        if (rx_d && !rx_s) begin
          cnt_nxt   = CW'(CLKS_PER_BIT / 2);
          state_nxt = START;
        end
      end
      START: begin
        if (!expired) begin
          cnt_nxt = cnt - 1'b1;
        end else if (rx_s) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt     = CW'(CLKS_PER_BIT - 1);
          bit_idx_nxt = 3'd0;
          state_nxt   = uart_pkg::DATA;
        end
      end
      uart_pkg::DATA: begin
        if (!expired) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          shreg_nxt   = {rx_s, shreg[7:1]};
          cnt_nxt     = CW'(CLKS_PER_BIT - 1);
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!expired) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          par_set   = (rx_s != ^shreg);
          cnt_nxt   = CW'(CLKS_PER_BIT - 1);
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (!expired) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          push_req  = rx_s;
          frame_set = !rx_s;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign VALID       = (count != '0);
  assign FULL        = (count == (AW+1)'(FIFO_DEPTH));
  assign pop_ok      = RD_EN && VALID;
  assign overrun_set = push_req && FULL && !pop_ok;

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push_req),
    .push_data (shreg),
    .pop       (pop_ok),
    .head      (DATA),
    .count     (count)
  );

  // Sticky flags: a set event in the same cycle as CLR_ERR wins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
      INTRPT    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      PAR_ERR   <= 1'b0;
`endif
    end else begin
      FRAME_ERR <= frame_set   || (FRAME_ERR && !CLR_ERR);
      OVERRUN   <= overrun_set || (OVERRUN && !CLR_ERR);
      INTRPT    <= push_req && (!FULL || pop_ok);
`ifdef UART_RX_PARITY_EN
      PAR_ERR   <= par_set     || (PAR_ERR && !CLR_ERR);
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at 16 clocks per bit
module tb_uart_rx;

  logic       CLK;
  logic       RST;
  logic       RX;
  logic       RD_EN;
  logic       CLR_ERR;
  logic [7:0] DATA;
  logic       VALID;
  logic       FULL;
  logic       FRAME_ERR;
  logic       OVERRUN;
  logic       INTRPT;
`ifdef UART_RX_PARITY_EN
  logic       PAR_ERR;
`endif

  int checks = 0;
  int failures = 0;
  int intr_count = 0;

  uart_rx #(
    .CLK_FREQ   (1600),
    .BAUD       (100),
    .FIFO_DEPTH (4)
  ) u_dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX        (RX),
    .RD_EN     (RD_EN),
    .CLR_ERR   (CLR_ERR),
    .DATA      (DATA),
    .VALID     (VALID),
    .FULL      (FULL),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN),
    .INTRPT    (INTRPT)
`ifdef UART_RX_PARITY_EN
    ,
    .PAR_ERR   (PAR_ERR)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(negedge CLK) begin
    if (INTRPT === 1'b1) intr_count++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (16) tick();
    end
    RX = stop;
    repeat (16) tick();
  endtask

  task automatic test_reset();
    RST = 1'b1; RX = 1'b1; RD_EN = 1'b0; CLR_ERR = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    checks++; if (DATA !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", DATA); end
    checks++; if (VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", VALID); end
    checks++; if (FULL !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", FULL); end
    checks++; if (FRAME_ERR !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", FRAME_ERR); end
    checks++; if (OVERRUN !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", OVERRUN); end
    checks++; if (INTRPT !== 1'b0) begin failures++; $display("FAIL reset_intrpt got=%b exp=0", INTRPT); end
  endtask

  task automatic test_single();
    int   cyc = 0;
    logic seen = 1'b0;
    logic intr_at_valid = 1'b0;
    int   i0 = intr_count;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int c = 1; c <= 200 && !seen; c++) begin
          tick();
          if (VALID === 1'b1) begin
            seen = 1'b1;
            cyc = c;
            intr_at_valid = INTRPT;
          end
        end
      end
    join
    checks++; if (!seen || cyc < 150 || cyc > 160) begin failures++; $display("FAIL single_latency got=%0d exp=150..160", cyc); end
    checks++; if (intr_at_valid !== 1'b1) begin failures++; $display("FAIL single_intrpt_with_valid got=%b exp=1", intr_at_valid); end
    checks++; if (intr_count - i0 != 1) begin failures++; $display("FAIL single_intrpt_pulses got=%0d exp=1", intr_count - i0); end
    checks++; if (DATA !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", DATA); end
    RD_EN = 1'b1; tick(); RD_EN = 1'b0;
    checks++; if (VALID !== 1'b0) begin failures++; $display("FAIL single_valid_after_pop got=%b exp=0", VALID); end
    checks++; if (DATA !== 8'h00) begin failures++; $display("FAIL single_data_after_pop got=%h exp=00", DATA); end
  endtask

  task automatic test_overrun();
    int i0 = intr_count;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    repeat (4) tick();
    checks++; if (FULL !== 1'b1) begin failures++; $display("FAIL ovr_full got=%b exp=1", FULL); end
    checks++; if (OVERRUN !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", OVERRUN); end
    checks++; if (intr_count - i0 != 4) begin failures++; $display("FAIL ovr_intrpt_pulses got=%0d exp=4", intr_count - i0); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (DATA !== 8'(i)) begin failures++; $display("FAIL ovr_pop%0d got=%h exp=%h", i, DATA, 8'(i)); end
      RD_EN = 1'b1; tick(); RD_EN = 1'b0;
    end
    checks++; if (VALID !== 1'b0) begin failures++; $display("FAIL ovr_empty got=%b exp=0", VALID); end
    CLR_ERR = 1'b1; tick(); CLR_ERR = 1'b0;
    checks++; if (OVERRUN !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", OVERRUN); end
  endtask

  task automatic test_full_pop();
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    // Stop sample of a frame lands 156 clocks after its start bit is driven.
    fork
      send_frame(8'h05, 1'b1);
      begin
        repeat (155) tick();
        RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
      end
    join
    checks++; if (OVERRUN !== 1'b0) begin failures++; $display("FAIL fullpop_overrun got=%b exp=0", OVERRUN); end
    checks++; if (FULL !== 1'b1) begin failures++; $display("FAIL fullpop_full got=%b exp=1", FULL); end
    for (int i = 2; i <= 5; i++) begin
      checks++; if (DATA !== 8'(i)) begin failures++; $display("FAIL fullpop_pop%0d got=%h exp=%h", i, DATA, 8'(i)); end
      RD_EN = 1'b1; tick(); RD_EN = 1'b0;
    end
    checks++; if (VALID !== 1'b0) begin failures++; $display("FAIL fullpop_empty got=%b exp=0", VALID); end
  endtask

  task automatic test_frame_err();
    int i0 = intr_count;
    send_frame(8'h3C, 1'b0);
    RX = 1'b1;
    repeat (16) tick();
    checks++; if (FRAME_ERR !== 1'b1) begin failures++; $display("FAIL ferr_flag got=%b exp=1", FRAME_ERR); end
    checks++; if (VALID !== 1'b0) begin failures++; $display("FAIL ferr_no_push got=%b exp=0", VALID); end
    checks++; if (intr_count != i0) begin failures++; $display("FAIL ferr_no_intrpt got=%0d exp=0", intr_count - i0); end
    send_frame(8'h7E, 1'b1);
    tick();
    checks++; if (DATA !== 8'h7E) begin failures++; $display("FAIL ferr_next_data got=%h exp=7e", DATA); end
    checks++; if (FRAME_ERR !== 1'b1) begin failures++; $display("FAIL ferr_sticky got=%b exp=1", FRAME_ERR); end
    RD_EN = 1'b1; tick(); RD_EN = 1'b0;
    CLR_ERR = 1'b1; tick(); CLR_ERR = 1'b0;
    checks++; if (FRAME_ERR !== 1'b0) begin failures++; $display("FAIL ferr_clear got=%b exp=0", FRAME_ERR); end
  endtask

  task automatic test_break();
    RX = 1'b0;
    repeat (480) tick();
    checks++; if (FRAME_ERR !== 1'b1) begin failures++; $display("FAIL break_flag got=%b exp=1", FRAME_ERR); end
    CLR_ERR = 1'b1; tick(); CLR_ERR = 1'b0;
    repeat (320) tick();
    checks++; if (FRAME_ERR !== 1'b0) begin failures++; $display("FAIL break_once got=%b exp=0", FRAME_ERR); end
    checks++; if (VALID !== 1'b0) begin failures++; $display("FAIL break_no_push got=%b exp=0", VALID); end
    RX = 1'b1;
    repeat (20) tick();
  endtask

  task automatic test_glitch();
    int i0 = intr_count;
    RX = 1'b0;
    repeat (5) tick();
    RX = 1'b1;
    repeat (200) tick();
    checks++; if (VALID !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%b exp=0", VALID); end
    checks++; if (FRAME_ERR !== 1'b0 || OVERRUN !== 1'b0) begin failures++; $display("FAIL glitch_flags got=%b%b exp=00", FRAME_ERR, OVERRUN); end
    checks++; if (intr_count != i0) begin failures++; $display("FAIL glitch_intrpt got=%0d exp=0", intr_count - i0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b = 8'h55;
    send_frame(8'h99, 1'b1);
    RX = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 4; i++) begin
      RX = b[i];
      repeat (16) tick();
    end
    RX = b[4];
    repeat (8) tick();
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    checks++; if (VALID !== 1'b0 || DATA !== 8'h00) begin failures++; $display("FAIL rst_fifo got=%b/%h exp=0/00", VALID, DATA); end
    checks++; if (FULL !== 1'b0 || FRAME_ERR !== 1'b0 || OVERRUN !== 1'b0 || INTRPT !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b%b%b exp=0000", FULL, FRAME_ERR, OVERRUN, INTRPT); end
    RX = 1'b1;
    repeat (100) tick();
    checks++; if (VALID !== 1'b0) begin failures++; $display("FAIL rst_partial_dropped got=%b exp=0", VALID); end
    send_frame(8'hC3, 1'b1);
    tick();
    checks++; if (DATA !== 8'hC3 || VALID !== 1'b1) begin failures++; $display("FAIL rst_next_frame got=%b/%h exp=1/c3", VALID, DATA); end
    RD_EN = 1'b1; tick(); RD_EN = 1'b0;
    checks++; if (VALID !== 1'b0) begin failures++; $display("FAIL rst_single_entry got=%b exp=0", VALID); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_full_pop();
    test_frame_err();
    test_break();
    test_glitch();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
